// File: rtl/bus_sequencer_if.sv
// Bus sequencer handshake and strobe bundle.
// master: the sequencer; slave: requesters and pins.
interface bus_sequencer_if;
  logic IReq;
  logic DReq;
  logic DWr;
  logic nWait;
  logic IAck;
  logic DAck;
  logic BusErr;
  logic Grant;
  logic Busy;
  logic ALE;
  logic nME;
  logic nOE;
  logic nWE;
  logic ENB;
  logic RdStb;

  modport master (
    input  IReq, DReq, DWr, nWait,
    output IAck, DAck, BusErr, Grant, Busy,
    output ALE, nME, nOE, nWE, ENB, RdStb
  );

  modport slave (
    output IReq, DReq, DWr, nWait,
    input  IAck, DAck, BusErr, Grant, Busy,
    input  ALE, nME, nOE, nWE, ENB, RdStb
  );
endinterface

// File: rtl/bus_sequencer.sv
// External bus cycle sequencer: fetch/data arbitration,
// address/data phases, wait stretching and timeout abort.
module bus_sequencer #(
  parameter int WS      = 1,
  parameter int TIMEOUT = 15,
  parameter int CW      = 4
) (
  input  logic          Clock,
  input  logic          nReset,
  bus_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_DONE
  } state_t;

  localparam logic [CW-1:0] L_WS  = CW'(WS);
  localparam logic [CW-1:0] L_TO  = CW'(TIMEOUT);
  localparam logic [CW-1:0] L_MAX = '1;

  state_t        r_state;
  logic          r_grant;
  logic          r_dwr;
  logic          r_err;
  logic          r_smp;
  logic [CW-1:0] r_cnt;

  logic          w_smp;
  logic [CW-1:0] w_tc;
  logic [CW-1:0] w_nxt;
  logic          w_addr;
  logic          w_data;
  logic          w_done;

  // Sampling starts once the fixed waits are spent; from then on
  // the counter restarts and holds the nWait-low cycles seen.
  assign w_smp = r_smp | (r_cnt >= L_WS);
  assign w_tc  = (!r_smp && w_smp) ? '0 : r_cnt;
  assign w_nxt = (w_tc == L_MAX) ? L_MAX : w_tc + 1'b1;

  assign w_addr = (r_state == S_ADDR);
  assign w_data = (r_state == S_DATA);
  assign w_done = (r_state == S_DONE);

  // Sequencer state, owner, direction and wait counter.
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      r_state <= S_IDLE;
      r_grant <= 1'b0;
      r_dwr   <= 1'b0;
      r_err   <= 1'b0;
      r_smp   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.DReq) begin
            r_grant <= 1'b1;
            r_dwr   <= bus.DWr;
            r_state <= S_ADDR;
          end else if (bus.IReq) begin
            r_grant <= 1'b0;
            r_dwr   <= 1'b0;
            r_state <= S_ADDR;
          end
        end
        S_ADDR: begin
          r_cnt   <= '0;
          r_smp   <= 1'b0;
          r_err   <= 1'b0;
          r_state <= S_DATA;
        end
        S_DATA: begin
          if (!w_smp) begin
            r_cnt <= w_nxt;
          end else if (bus.nWait) begin
            r_state <= S_DONE;
          end else if (w_tc >= L_TO) begin
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_smp <= 1'b1;
            r_cnt <= w_nxt;
          end
        end
        S_DONE: begin
          if (r_grant && bus.IReq) begin
            r_grant <= 1'b0;
            r_dwr   <= 1'b0;
            r_state <= S_ADDR;
          end else if (!r_grant && bus.DReq) begin
            r_grant <= 1'b1;
            r_dwr   <= bus.DWr;
            r_state <= S_ADDR;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ALE    = w_addr;
  assign bus.nME    = !(w_addr || w_data);
  assign bus.nOE    = !(w_data && !r_dwr);
  assign bus.nWE    = !(w_data && r_dwr);
  assign bus.ENB    = w_addr || (w_data && r_dwr);
  assign bus.IAck   = w_done && !r_grant;
  assign bus.DAck   = w_done && r_grant;
  assign bus.BusErr = w_done && r_err;
  assign bus.Grant  = r_grant;
  assign bus.Busy   = (r_state != S_IDLE);
  assign bus.RdStb  = w_data && !r_dwr && w_smp && bus.nWait;

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed and random checks for bus_sequencer.
// Expected acks are queued at request time and popped on ack.
module tb_bus_sequencer;

  typedef struct {
    bit d;
    bit err;
    int due;
  } exp_t;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  int   cyc  = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   sb_on   = 1'b1;
  exp_t sbq[$];

  bit i_pend = 0;
  bit d_pend = 0;
  int i_age = 0;
  int d_age = 0;
  int i_req = 0;
  int d_req = 0;
  int i_ack = 0;
  int d_ack = 0;

  bus_sequencer_if bus ();

  bus_sequencer #(
    .WS(1),
    .TIMEOUT(15),
    .CW(4)
  ) dut (
    .Clock(clk),
    .nReset(nrst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    chk("inv_ale", bus.ALE && (!bus.nOE || !bus.nWE), 0);
    chk("inv_oewe", !bus.nOE && !bus.nWE, 0);
    chk("inv_acks", bus.IAck && bus.DAck, 0);
    if (bus.IAck || bus.DAck) begin
      if (sb_on) begin
        n_tests++;
        assert (sbq.size() != 0) else begin
          n_fail++;
          $error("FAIL sb_unexp obs=ack@%0d exp=none", cyc);
        end
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("sb_kind", bus.DAck, e.d);
          chk("sb_err", bus.BusErr, e.err);
          chk("sb_due", cyc, e.due);
        end
      end else begin
        if (bus.IAck) begin
          chk("soak_iack_pend", i_pend, 1);
          i_pend = 0;
          i_ack++;
        end
        if (bus.DAck) begin
          chk("soak_dack_pend", d_pend, 1);
          d_pend = 0;
          d_ack++;
        end
      end
      if (bus.IAck) bus.IReq = 1'b0;
      if (bus.DAck) bus.DReq = 1'b0;
    end
  endtask

  initial begin
    int c0;
    int lows;
    int rds;
    bus.IReq  = 1'b0;
    bus.DReq  = 1'b0;
    bus.DWr   = 1'b0;
    bus.nWait = 1'b1;
    nrst      = 1'b0;
    repeat (3) tick();
    nrst = 1'b1;
    chk("rst_vec",
        {bus.ALE, bus.nME, bus.nOE, bus.nWE, bus.ENB,
         bus.IAck, bus.DAck, bus.BusErr, bus.RdStb,
         bus.Grant, bus.Busy},
        11'b01110000000);
    tick();
    chk("rst_idle", bus.Busy, 0);

    // fetch read, no waits beyond WS
    bus.IReq = 1'b1;
    c0 = cyc;
    sbq.push_back('{d: 1'b0, err: 1'b0, due: c0 + 4});
    tick();
    chk("f_addr", {bus.ALE, bus.nME, bus.ENB, bus.Busy}, 4'b1011);
    tick();
    chk("f_d1", {bus.nOE, bus.nWE, bus.RdStb, bus.ENB}, 4'b0100);
    tick();
    chk("f_d2", {bus.nOE, bus.nWE, bus.RdStb, bus.ENB}, 4'b0110);
    tick();
    chk("f_done", {bus.nME, bus.nOE, bus.ENB}, 3'b110);
    tick();
    chk("f_idle", bus.Busy, 0);

    // data write, nWait low three sampled cycles
    bus.DWr  = 1'b1;
    bus.DReq = 1'b1;
    c0 = cyc;
    sbq.push_back('{d: 1'b1, err: 1'b0, due: c0 + 7});
    tick();
    chk("w_grant", {bus.Grant, bus.ALE, bus.ENB}, 3'b111);
    for (int k = 2; k <= 6; k++) begin
      tick();
      if (k == 3) bus.nWait = 1'b0;
      if (k == 4) bus.DWr = 1'b0;
      if (k == 6) bus.nWait = 1'b1;
      chk("w_data",
          {bus.nWE, bus.ENB, bus.nOE, bus.nME, bus.RdStb},
          5'b01100);
    end
    tick();
    tick();
    chk("w_idle", bus.Busy, 0);

    // simultaneous requests: data first, fetch from DONE
    bus.DWr  = 1'b0;
    bus.IReq = 1'b1;
    bus.DReq = 1'b1;
    c0 = cyc;
    sbq.push_back('{d: 1'b1, err: 1'b0, due: c0 + 4});
    sbq.push_back('{d: 1'b0, err: 1'b0, due: c0 + 8});
    tick();
    chk("s_g1", {bus.ALE, bus.Grant}, 2'b11);
    repeat (3) tick();
    tick();
    chk("s_g0", {bus.ALE, bus.Grant, bus.Busy}, 3'b101);
    repeat (3) tick();
    tick();
    chk("s_idle", bus.Busy, 0);

    // fetch first, data raised mid-cycle then served from DONE
    bus.IReq = 1'b1;
    c0 = cyc;
    sbq.push_back('{d: 1'b0, err: 1'b0, due: c0 + 4});
    tick();
    tick();
    bus.DWr  = 1'b1;
    bus.DReq = 1'b1;
    sbq.push_back('{d: 1'b1, err: 1'b0, due: c0 + 8});
    tick();
    tick();
    tick();
    chk("r_g1", {bus.ALE, bus.Grant}, 2'b11);
    tick();
    chk("r_wr", {bus.nWE, bus.nOE}, 2'b01);
    repeat (2) tick();
    tick();
    chk("r_idle", bus.Busy, 0);

    // timeout with nWait stuck low
    bus.DWr   = 1'b0;
    bus.DReq  = 1'b1;
    bus.nWait = 1'b0;
    c0 = cyc;
    sbq.push_back('{d: 1'b1, err: 1'b1, due: c0 + 19});
    lows = 0;
    rds  = 0;
    for (int k = 1; k <= 19; k++) begin
      tick();
      lows += int'(!bus.nOE);
      rds  += int'(bus.RdStb);
    end
    chk("t_len", lows, 17);
    chk("t_rd", rds, 0);
    bus.nWait = 1'b1;
    tick();
    chk("t_idle", bus.Busy, 0);

    // reset during the data phase of a read
    bus.IReq  = 1'b1;
    bus.nWait = 1'b0;
    tick();
    tick();
    chk("x_data", {bus.nOE, bus.Busy}, 2'b01);
    nrst = 1'b0;
    tick();
    chk("x_rst",
        {bus.nOE, bus.nME, bus.Busy, bus.IAck, bus.Grant},
        5'b11000);
    nrst      = 1'b1;
    bus.IReq  = 1'b0;
    bus.nWait = 1'b1;
    tick();
    bus.IReq = 1'b1;
    c0 = cyc;
    sbq.push_back('{d: 1'b0, err: 1'b0, due: c0 + 4});
    repeat (4) tick();
    tick();
    chk("x_idle", bus.Busy, 0);
    chk("sb_empty", sbq.size(), 0);

    // random soak
    sb_on = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      tick();
      if (i_pend) i_age++;
      if (d_pend) d_age++;
      chk("soak_age", (i_age > 80) || (d_age > 80), 0);
      if (!i_pend && $urandom_range(0, 3) == 0) begin
        bus.IReq = 1'b1;
        i_pend = 1;
        i_age = 0;
        i_req++;
      end
      if (!d_pend && $urandom_range(0, 3) == 0) begin
        bus.DWr  = 1'($urandom_range(0, 1));
        bus.DReq = 1'b1;
        d_pend = 1;
        d_age = 0;
        d_req++;
      end
      bus.nWait = ($urandom_range(0, 3) != 0);
    end
    bus.nWait = 1'b1;
    for (int n = 0; n < 200 && (i_pend || d_pend); n++) tick();
    chk("soak_drain", i_pend || d_pend, 0);
    chk("soak_icount", i_ack, i_req);
    chk("soak_dcount", d_ack, d_req);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
